// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer
//   Produces the phase-timing pulses for the traffic-light controller. It
//   follows the lamp outputs to know which phase is running and which approach
//   holds the right of way. Green is demand-actuated: a minimum green, gap-out
//   when the active queue empties or a rival queue fills, and a hard maximum.
//   The yellow interval is timed here. Illegal lamp patterns and a controller
//   that stops answering drive the block into a sticky fault.
// Ports
//   i_clock, i_reset_b          clock (rising edge), async active-low reset
//   i_green/i_yellow/i_red[4]   lamp states, index W=0 S=1 E=2 N=3
//   i_{w,s,e,n}_sensor[2]       queue level per approach, 0..3
//   o_g2y_timer                 one-cycle pulse: end the current green
//   o_y2r_timer                 one-cycle pulse: end the current yellow
//   o_phase[3]                  0 WAIT_GREEN 1 GREEN 2 G2Y_WAIT 3 YELLOW 4 RED_WAIT 5 FAULT
//   o_active_dir[2]             approach holding green or yellow
//   o_fault                     sticky fault flag

// Per-approach lamp check: exactly one of red/yellow/green must be lit.
module tlc_lamp_check (
    input  logic red,
    input  logic yellow,
    input  logic green,
    output logic illegal,
    output logic lit
);
    // Odd parity with "not all three" means exactly one lamp is on.
    assign illegal = !((red ^ yellow ^ green) && !(red && yellow && green));
    assign lit     = !red;
endmodule

module tlc_phase_timer #(
    parameter int GREEN_MIN   = 8,
    parameter int GREEN_MAX   = 32,
    parameter int YELLOW_TIME = 4,
    parameter int ACK_TIMEOUT = 8,
    parameter int CNT_W       = 8
) (
    input  logic       i_clock,
    input  logic       i_reset_b,
    input  logic [3:0] i_green,
    input  logic [3:0] i_yellow,
    input  logic [3:0] i_red,
    input  logic [1:0] i_w_sensor,
    input  logic [1:0] i_s_sensor,
    input  logic [1:0] i_e_sensor,
    input  logic [1:0] i_n_sensor,
    output logic       o_g2y_timer,
    output logic       o_y2r_timer,
    output logic [2:0] o_phase,
    output logic [1:0] o_active_dir,
    output logic       o_fault
);
    localparam int NUM_DIRS = 4;

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ACK_M1  = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_GREEN = 3'd0,
        GREEN      = 3'd1,
        G2Y_WAIT   = 3'd2,
        YELLOW     = 3'd3,
        RED_WAIT   = 3'd4,
        FAULT      = 3'd5
    } phase_t;

    logic [NUM_DIRS-1:0]      green_q, yellow_q, red_q;
    logic [NUM_DIRS-1:0][1:0] sens_q;
    logic [NUM_DIRS-1:0]      illegal, lit;

    phase_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]       dir, dir_n, green_idx;
    logic             g2y_n, y2r_n;
    logic             lamp_bad, one_green, gap;

    // Input registers. The lamp copy resets to all-red so the legality check
    // sees a valid pattern before the first real sample arrives.
    always_ff @(posedge i_clock or negedge i_reset_b) begin
        if (!i_reset_b) begin
            green_q  <= '0;
            yellow_q <= '0;
            red_q    <= '1;
            sens_q   <= '0;
        end else begin
            green_q  <= i_green;
            yellow_q <= i_yellow;
            red_q    <= i_red;
            sens_q   <= {i_n_sensor, i_e_sensor, i_s_sensor, i_w_sensor};
        end
    end

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_lamp
        tlc_lamp_check u_chk (
            .red    (red_q[i]),
            .yellow (yellow_q[i]),
            .green  (green_q[i]),
            .illegal(illegal[i]),
            .lit    (lit[i])
        );
    end

    // More than one non-red approach is caught by the clear-lowest-bit test.
    assign lamp_bad  = (|illegal) || ((lit & (lit - 4'd1)) != 4'd0);
    assign one_green = (green_q != 4'd0) && ((green_q & (green_q - 4'd1)) == 4'd0);
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        green_idx = 2'd0;
        for (int i = 0; i < NUM_DIRS; i++)
            if (green_q[i]) green_idx = 2'(i);
    end

    // Gap-out demand: active queue empty, or any rival queue full.
    always_comb begin
        gap = (sens_q[dir] == 2'd0);
        for (int i = 0; i < NUM_DIRS; i++)
            if (2'(i) != dir && sens_q[i] == 2'd3) gap = 1'b1;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir;
        g2y_n   = 1'b0;
        y2r_n   = 1'b0;
        case (state)
            WAIT_GREEN: begin
                if (one_green && yellow_q == 4'd0) begin
                    dir_n   = green_idx;
                    cnt_n   = '0;
                    state_n = GREEN;
                end
            end
            GREEN: begin
                if (cnt == GMAX_M1 || (cnt >= GMIN_M1 && gap)) begin
                    g2y_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = G2Y_WAIT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            G2Y_WAIT: begin
                // A late answer in the last allowed cycle still counts.
                if (yellow_q[dir]) begin
                    cnt_n   = '0;
                    state_n = YELLOW;
                end else if (cnt == ACK_M1) begin
                    state_n = FAULT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            YELLOW: begin
                if (cnt == YEL_M1) begin
                    y2r_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = RED_WAIT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            RED_WAIT: begin
                if (one_green) begin
                    dir_n   = green_idx;
                    cnt_n   = '0;
                    state_n = GREEN;
                end else if (cnt == ACK_M1) begin
                    state_n = FAULT;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            FAULT:   state_n = FAULT;
            default: state_n = FAULT;
        endcase
        // Bad lamps override whatever the phase logic decided this cycle.
        if (state != FAULT && lamp_bad) begin
            state_n = FAULT;
            cnt_n   = cnt;
            dir_n   = dir;
            g2y_n   = 1'b0;
            y2r_n   = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_b) begin
        if (!i_reset_b) begin
            state       <= WAIT_GREEN;
            cnt         <= '0;
            dir         <= 2'd0;
            o_g2y_timer <= 1'b0;
            o_y2r_timer <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            dir         <= dir_n;
            o_g2y_timer <= g2y_n;
            o_y2r_timer <= y2r_n;
            o_fault     <= (state_n == FAULT);
        end
    end

    assign o_phase      = state;
    assign o_active_dir = dir;
endmodule

// File: tb/tb_tlc_phase_timer.sv
// Bench for tlc_phase_timer: a model controller answers each pulse two cycles
// later; expected green length per phase is computed from the sensor schedule.
module tb_tlc_phase_timer;
    localparam int GMIN = 4;
    localparam int GMAX = 10;
    localparam int YT   = 3;
    localparam int ACK  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] green, yellow, red;
    logic [1:0] ws, ss, es, ns;
    logic       g2y, y2r, fault;
    logic [2:0] phase;
    logic [1:0] adir;

    int checks = 0;
    int errors = 0;
    int sched [1:GMAX][4];   // queue level seen in each green cycle, per approach

    tlc_phase_timer #(
        .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_TIME(YT),
        .ACK_TIMEOUT(ACK), .CNT_W(8)
    ) dut (
        .i_clock(clk), .i_reset_b(rst_n),
        .i_green(green), .i_yellow(yellow), .i_red(red),
        .i_w_sensor(ws), .i_s_sensor(ss), .i_e_sensor(es), .i_n_sensor(ns),
        .o_g2y_timer(g2y), .o_y2r_timer(y2r), .o_phase(phase),
        .o_active_dir(adir), .o_fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // color: 0 all red, 1 green on dir, 2 yellow on dir
    task automatic set_lamps(input int dir, input int color);
        green  = 4'h0;
        yellow = 4'h0;
        red    = 4'hF;
        if (color != 0) begin
            red[dir] = 1'b0;
            if (color == 1) green[dir] = 1'b1;
            else            yellow[dir] = 1'b1;
        end
    endtask

    task automatic set_sens(input int n);
        ws = 2'(sched[n][0]);
        ss = 2'(sched[n][1]);
        es = 2'(sched[n][2]);
        ns = 2'(sched[n][3]);
    endtask

    task automatic fill_const(input int w, input int s, input int e, input int n);
        for (int c = 1; c <= GMAX; c++) begin
            sched[c][0] = w; sched[c][1] = s; sched[c][2] = e; sched[c][3] = n;
        end
    endtask

    task automatic fill_rand();
        int r;
        for (int c = 1; c <= GMAX; c++)
            for (int i = 0; i < 4; i++) begin
                r = int'($urandom_range(0, 15));
                sched[c][i] = (r == 0) ? 0 : (r == 1) ? 3 : 1 + (r % 2);
            end
    endtask

    // Green length in cycles: first cycle at or past the minimum with demand
    // to move on, otherwise the maximum.
    function automatic int green_len(input int dir);
        bit other_full;
        for (int c = 1; c <= GMAX; c++) begin
            other_full = 1'b0;
            for (int i = 0; i < 4; i++)
                if (i != dir && sched[c][i] == 3) other_full = 1'b1;
            if (c == GMAX) return c;
            if (c >= GMIN && (sched[c][dir] == 0 || other_full)) return c;
        end
        return GMAX;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        set_lamps(0, 0);
        fill_const(1, 1, 1, 1);
        set_sens(1);
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_phase", 8'(phase), 8'd0);
    endtask

    // mode 0: full cycle, 1: controller never shows yellow, 2: reset mid-yellow
    task automatic run_phase(input int dir, input int mode);
        int n;
        n = green_len(dir);
        set_lamps(dir, 1);
        set_sens(1);
        for (int t = 1; t <= n + 2; t++) begin
            step();
            chk("g2y_green", 8'(g2y), 8'(t == n + 2));
            chk("y2r_green", 8'(y2r), 8'd0);
            if (t == 2) begin
                chk("phase_green", 8'(phase), 8'd1);
                chk("active_dir", 8'(adir), 8'(dir));
            end
            set_sens((t < GMAX) ? ((t < 1) ? 1 : t) : GMAX);
        end
        chk("phase_g2y_wait", 8'(phase), 8'd2);
        if (mode == 1) begin
            for (int k = 1; k <= ACK; k++) begin
                step();
                chk("g2y_noresp", 8'(g2y), 8'd0);
                chk("phase_noresp", 8'(phase), (k == ACK) ? 8'd5 : 8'd2);
            end
            chk("fault_noresp", 8'(fault), 8'd1);
            return;
        end
        for (int k = 1; k <= 2; k++) begin
            step();
            chk("g2y_wait", 8'(g2y), 8'd0);
            chk("phase_wait", 8'(phase), 8'd2);
        end
        set_lamps(dir, 2);
        for (int k = 3; k <= 4 + YT; k++) begin
            step();
            chk("g2y_yellow", 8'(g2y), 8'd0);
            chk("y2r_yellow", 8'(y2r), 8'(k == 4 + YT));
            if (k == 4) chk("phase_yellow", 8'(phase), 8'd3);
            if (mode == 2 && k == 5) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst_phase", 8'(phase), 8'd0);
                chk("async_rst_g2y", 8'(g2y), 8'd0);
                chk("async_rst_y2r", 8'(y2r), 8'd0);
                chk("async_rst_fault", 8'(fault), 8'd0);
                chk("async_rst_dir", 8'(adir), 8'd0);
                set_lamps(0, 0);
                step();
                step();
                rst_n = 1'b1;
                step();
                chk("after_rst_phase", 8'(phase), 8'd0);
                chk("after_rst_y2r", 8'(y2r), 8'd0);
                return;
            end
        end
        chk("phase_red_wait", 8'(phase), 8'd4);
        step();
        chk("y2r_once", 8'(y2r), 8'd0);
        set_lamps(0, 0);
        step();
        chk("phase_red_hold", 8'(phase), 8'd4);
        chk("g2y_red", 8'(g2y), 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_lamps(0, 0);
        fill_const(1, 1, 1, 1);
        set_sens(1);
        step();
        step();
        chk("reset_phase", 8'(phase), 8'd0);
        chk("reset_g2y", 8'(g2y), 8'd0);
        chk("reset_y2r", 8'(y2r), 8'd0);
        chk("reset_fault", 8'(fault), 8'd0);
        chk("reset_dir", 8'(adir), 8'd0);
        rst_n = 1'b1;
        step();
        chk("idle_phase", 8'(phase), 8'd0);

        // Max-out: busy west, moderate rivals.
        fill_const(3, 1, 1, 1);
        run_phase(0, 0);

        // Gap-out: west empties from cycle 2, pulse no earlier than minimum.
        fill_const(2, 1, 1, 1);
        for (int c = 2; c <= GMAX; c++) sched[c][0] = 0;
        run_phase(0, 0);

        // Competing demand: east fills from cycle 6.
        fill_const(2, 1, 1, 1);
        for (int c = 6; c <= GMAX; c++) sched[c][2] = 3;
        run_phase(0, 0);

        repeat (10) begin
            fill_rand();
            run_phase(int'($urandom_range(0, 3)), 0);
        end

        // Reset in the middle of yellow, then normal cycling.
        fill_const(1, 2, 1, 1);
        run_phase(1, 2);
        fill_rand();
        run_phase(2, 0);

        // Controller never answers the g2y pulse.
        fill_const(1, 1, 1, 2);
        run_phase(3, 1);
        repeat (6) begin
            step();
            chk("fault_sticky", 8'(fault), 8'd1);
            chk("fault_no_g2y", 8'(g2y), 8'd0);
            chk("fault_no_y2r", 8'(y2r), 8'd0);
            chk("fault_phase", 8'(phase), 8'd5);
        end

        // Two approaches non-red while waiting for green.
        do_reset();
        green = 4'b0101; red = 4'b1010; yellow = 4'b0000;
        step();
        chk("illegal2_early", 8'(phase), 8'd0);
        step();
        chk("illegal2_phase", 8'(phase), 8'd5);
        chk("illegal2_fault", 8'(fault), 8'd1);

        // Red and green together on one approach; beats the green transition.
        do_reset();
        set_lamps(2, 1);
        red[2] = 1'b1;
        step();
        chk("illegal_rg_early", 8'(phase), 8'd0);
        step();
        chk("illegal_rg_phase", 8'(phase), 8'd5);

        // Illegal pattern arriving during green.
        do_reset();
        fill_const(1, 1, 1, 2);
        set_sens(1);
        set_lamps(3, 1);
        step();
        step();
        chk("illegal_g_pre", 8'(phase), 8'd1);
        green = 4'b0101; red = 4'b1010; yellow = 4'b0000;
        step();
        chk("illegal_g_early", 8'(phase), 8'd1);
        step();
        chk("illegal_g_phase", 8'(phase), 8'd5);
        chk("illegal_g_nopulse", 8'(g2y), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
